// File: rtl/network_pkg.sv
// Shared types and constants for the per-sample network sequencer.
package network_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        START,
        WAIT,
        LATCH
    } seq_state_t;

endpackage

// File: rtl/sample_shift_buffer.sv
// History buffer of the most recent TAPS samples. Slot 0 holds the newest
// sample and slot TAPS-1 the oldest. Advances only when en is high.
module sample_shift_buffer #(
    parameter int W    = 16,
    parameter int TAPS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [W-1:0]      inp,
    output logic [TAPS*W-1:0] out
);

    logic [W-1:0] slot_reg [TAPS];

    // Each enable moves every sample one slot older and loads the new one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                slot_reg[k] <= '0;
            end
        end else if (en) begin
            slot_reg[0] <= inp;
            for (int k = 1; k < TAPS; k++) begin
                slot_reg[k] <= slot_reg[k-1];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_pack
            assign out[gi*W +: W] = slot_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/network_sequencer.sv
// Per-sample controller: detects the sample strobe edge, updates the
// history buffer, walks the layer chain with start/done handshakes and
// latches the final results. Also handles bypass, overrun and a per-layer
// watchdog.
module network_sequencer
    import network_pkg::*;
#(
    parameter int W        = SAMPLE_W,
    parameter int N_CH     = 4,
    parameter int TAPS     = 4,
    parameter int N_LAYERS = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_clk,
    input  logic [W-1:0]        sample_in,
    input  logic                bypass,
    output logic [TAPS*W-1:0]   taps,
    output logic [N_LAYERS-1:0] layer_start,
    input  logic [N_LAYERS-1:0] layer_done,
    input  logic [N_CH*W-1:0]   final_in,
    output logic [N_CH*W-1:0]   sample_out,
    output logic                busy,
    output logic                overrun,
    output logic                timeout_err,
    input  logic                err_clr
);

    localparam int IDX_W  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int WDOG_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_LAYERS - 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

    seq_state_t        state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [WDOG_W-1:0] wdog_reg;
    logic [W-1:0]      hold_reg;
    logic              prev_sample_clk_reg;
    logic              rise;

    // Only a low-to-high transition of the strobe starts a computation.
    assign rise = sample_clk & ~prev_sample_clk_reg;
    assign busy = (state_reg != IDLE);

    sample_shift_buffer #(
        .W    (W),
        .TAPS (TAPS)
    ) u_history (
        .clk (clk),
        .rst (rst),
        .en  (state_reg == SHIFT),
        .inp (hold_reg),
        .out (taps)
    );

    // Sequencer FSM with edge detect, watchdog, sticky flags and output latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= IDLE;
            idx_reg             <= '0;
            wdog_reg            <= '0;
            hold_reg            <= '0;
            prev_sample_clk_reg <= 1'b1;  // a strobe held high through reset is not an edge
            layer_start         <= '0;
            sample_out          <= '0;
            overrun             <= 1'b0;
            timeout_err         <= 1'b0;
        end else begin
            prev_sample_clk_reg <= sample_clk;
            layer_start         <= '0;

            // Clear first so that a same-cycle set event takes priority.
            if (err_clr) begin
                overrun     <= 1'b0;
                timeout_err <= 1'b0;
            end
            if (rise && (state_reg != IDLE)) begin
                overrun <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (rise) begin
                        hold_reg  <= sample_in;
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bypass) begin
                        state_reg <= LATCH;
                    end else begin
                        idx_reg        <= '0;
                        layer_start[0] <= 1'b1;
                        state_reg      <= START;
                    end
                end
                START: begin
                    wdog_reg  <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    wdog_reg <= wdog_reg + 1'b1;
                    if (layer_done[idx_reg]) begin
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= LATCH;
                        end else begin
                            idx_reg                       <= idx_reg + 1'b1;
                            layer_start[idx_reg + 1'b1]   <= 1'b1;
                            state_reg                     <= START;
                        end
                    end else if (wdog_reg == WDOG_LIMIT) begin
                        timeout_err <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                LATCH: begin
                    sample_out <= bypass ? {N_CH{hold_reg}} : final_in;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_network_sequencer.sv
// Directed and randomized checks of network_sequencer against a queue-based
// history model and cycle-count latency expectations.
module tb_network_sequencer;

    localparam int W        = 16;
    localparam int N_CH     = 4;
    localparam int TAPS     = 4;
    localparam int N_LAYERS = 2;
    localparam int TIMEOUT  = 8;

    logic                clk;
    logic                rst;
    logic                sample_clk;
    logic [W-1:0]        sample_in;
    logic                bypass;
    logic [TAPS*W-1:0]   taps;
    logic [N_LAYERS-1:0] layer_start;
    logic [N_LAYERS-1:0] layer_done;
    logic [N_CH*W-1:0]   final_in;
    logic [N_CH*W-1:0]   sample_out;
    logic                busy;
    logic                overrun;
    logic                timeout_err;
    logic                err_clr;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0]      hist_q[$];
    logic [N_CH*W-1:0] model_out;

    network_sequencer #(
        .W        (W),
        .N_CH     (N_CH),
        .TAPS     (TAPS),
        .N_LAYERS (N_LAYERS),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_clk  (sample_clk),
        .sample_in   (sample_in),
        .bypass      (bypass),
        .taps        (taps),
        .layer_start (layer_start),
        .layer_done  (layer_done),
        .final_in    (final_in),
        .sample_out  (sample_out),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [TAPS*W-1:0] model_taps();
        logic [TAPS*W-1:0] v;
        for (int k = 0; k < TAPS; k++) v[k*W +: W] = hist_q[k];
        return v;
    endfunction

    task automatic model_reset();
        hist_q.delete();
        for (int k = 0; k < TAPS; k++) hist_q.push_back('0);
        model_out = '0;
    endtask

    // One full sample computation. d0/d1 are the done delays of each layer
    // (cycles after its start); a negative delay means that layer never answers.
    task automatic run_sample(input logic [W-1:0] s, input bit byp,
                              input int d0, input int d1,
                              input logic [N_CH*W-1:0] fin, input bit inject);
        int d [2];
        d[0] = d0;
        d[1] = d1;
        final_in   = fin;
        sample_in  = s;
        bypass     = byp;
        sample_clk = 1'b1;
        tick();                                   // t+1
        sample_clk = 1'b0;
        hist_q.push_front(s);
        void'(hist_q.pop_back());
        chk("busy_after_rise", busy, 1);
        if (byp) begin
            tick();                               // t+2
            chk("busy_latch", busy, 1);
            chk("no_start_bypass", layer_start, 0);
            chk("out_hold_bypass", sample_out, model_out);
            tick();                               // t+3
            model_out = {N_CH{s}};
            chk("busy_end_bypass", busy, 0);
            chk("out_bypass", sample_out, model_out);
        end else begin
            for (int l = 0; l < N_LAYERS; l++) begin
                tick();                           // start cycle of layer l
                layer_done = '0;
                chk($sformatf("start_l%0d", l), layer_start, 64'(1) << l);
                if (d[l] < 0) begin
                    for (int c = 1; c <= TIMEOUT; c++) begin
                        tick();
                        chk("wait_no_start", layer_start, 0);
                    end
                    chk("busy_before_to", busy, 1);
                    chk("no_to_yet", timeout_err, 0);
                    tick();
                    chk("timeout_set", timeout_err, 1);
                    chk("idle_after_to", busy, 0);
                    chk("out_kept_to", sample_out, model_out);
                    chk("taps_to", taps, model_taps());
                    return;
                end
                for (int c = 1; c <= d[l]; c++) begin
                    tick();
                    chk("wait_no_start", layer_start, 0);
                    chk("busy_wait", busy, 1);
                    if (inject && l == 0 && c == 1) begin
                        sample_clk = 1'b1;
                        err_clr    = 1'b1;
                        sample_in  = ~s;
                    end else if (inject && l == 0 && c == 2) begin
                        sample_clk = 1'b0;
                        err_clr    = 1'b0;
                        chk("overrun_set", overrun, 1);
                    end
                    if (c == d[l]) layer_done[l] = 1'b1;
                end
            end
            tick();                               // LATCH
            layer_done = '0;
            chk("busy_latch", busy, 1);
            chk("out_not_early", sample_out, model_out);
            tick();
            model_out = fin;
            chk("out_chain", sample_out, model_out);
            chk("busy_end_chain", busy, 0);
            chk("no_extra_start", layer_start, 0);
        end
        chk("taps", taps, model_taps());
    endtask

    initial begin
        logic [N_CH*W-1:0] fin;
        rst        = 1'b1;
        sample_clk = 1'b0;
        sample_in  = '0;
        bypass     = 1'b0;
        layer_done = '0;
        final_in   = '0;
        err_clr    = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_taps", taps, 0);
        chk("rst_out", sample_out, 0);
        chk("rst_start", layer_start, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 1'b0;
        tick();

        // Bypass with default value
        run_sample(16'h1234, 1'b1, 0, 0, '0, 1'b0);
        chk("bypass_all_ch", sample_out, 64'h1234_1234_1234_1234);

        // History depth
        for (int i = 1; i <= 5; i++) run_sample(16'(i), 1'b1, 0, 0, '0, 1'b0);
        chk("history_5432", taps, 64'h0002_0003_0004_0005);

        // Two-layer chain with fixed outputs {-4,3,-2,1}
        fin = {16'hFFFC, 16'h0003, 16'hFFFE, 16'h0001};
        run_sample(16'h00A5, 1'b0, 3, 3, fin, 1'b0);
        chk("chain_fixed", sample_out, 64'hFFFC_0003_FFFE_0001);

        // Shortest possible done latency
        run_sample(16'(($urandom)), 1'b0, 1, 1, {$urandom, $urandom}, 1'b0);

        // Randomized mix of bypass and chained runs
        for (int i = 0; i < 12; i++) begin
            run_sample(16'($urandom), 1'($urandom), $urandom_range(1, 6),
                       $urandom_range(1, 6), {$urandom, $urandom}, 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        // Overrun during WAIT, with err_clr in the same cycle as the set
        run_sample(16'h5A5A, 1'b0, 4, 3, {$urandom, $urandom}, 1'b1);
        repeat (3) begin
            tick();
            chk("single_latch_idle", busy, 0);
            chk("single_latch_nostart", layer_start, 0);
        end
        chk("overrun_sticky", overrun, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("overrun_cleared", overrun, 0);

        // Watchdog on layer 1
        run_sample(16'h0BEE, 1'b0, 2, -1, {$urandom, $urandom}, 1'b0);
        tick();
        chk("timeout_sticky", timeout_err, 1);
        run_sample(16'h0C0F, 1'b0, 2, 2, {$urandom, $urandom}, 1'b0);
        chk("timeout_still", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("timeout_cleared", timeout_err, 0);

        // Reset in the middle of WAIT with the strobe held high
        sample_in  = 16'h7777;
        bypass     = 1'b0;
        sample_clk = 1'b1;
        repeat (3) tick();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_taps", taps, 0);
        chk("mid_rst_out", sample_out, 0);
        chk("mid_rst_start", layer_start, 0);
        repeat (4) begin
            tick();
            chk("held_strobe_idle", busy, 0);
            chk("held_strobe_nostart", layer_start, 0);
        end
        sample_clk = 1'b0;
        tick();
        run_sample(16'h4321, 1'b0, 2, 5, {$urandom, $urandom}, 1'b0);
        run_sample(16'h8001, 1'b1, 0, 0, '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
